// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg: default video timing, line/frame total helper, pattern      |
// | colours shared by the timing generator and its counters.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VFP    = 13;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 29;

  localparam int RGB_W = 24;
  localparam logic [RGB_W-1:0] WHITE = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BLACK = 24'h000000;

  function automatic int vga_total(input int disp, input int fp, input int pulse, input int bp);
    return disp + fp + pulse + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen_if: video output bundle (CLK, HS, VS, BLANK, RGB and  |
// | frame marker) between the timing generator and its sink.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic             video_CLK;
  logic             video_HS;
  logic             video_VS;
  logic             video_BLANK;
  logic [RGB_W-1:0] video_RGB;
  logic             frame_start;

  modport master (
    output video_CLK, video_HS, video_VS, video_BLANK, video_RGB, frame_start
  );

  modport slave (
    input video_CLK, video_HS, video_VS, video_BLANK, video_RGB, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_counter: enabled wrap-around counter 0..MAX-1 with a wrap strobe |
// | that is high on the enabled cycle leaving MAX-1.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_counter #(
  parameter int MAX = 288,
  parameter int W   = 9
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         en_i,
  output logic [W-1:0]      cnt_o,
  output logic              wrap_o
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & at_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen: free-running video timing generator with registered  |
// | HS/VS/BLANK and a 16-pixel white grid test pattern.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int VDISP  = DEF_VDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP
) (
  input  wire logic           pixel_clk,
  input  wire logic           pixel_rst,
  vga_timing_gen_if.master    video
);

  localparam int HTOTAL = vga_total(HDISP, HFP, HPULSE, HBP);
  localparam int VTOTAL = vga_total(VDISP, VFP, VPULSE, VBP);
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_SYNC_S = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT_S  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT_S  = VW'(VFP + VPULSE + VBP);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_wrap;
  logic          v_wrap_unused;

  vga_counter #(.MAX(HTOTAL), .W(HW)) u_hcnt (
    .clk    (pixel_clk),
    .rst    (pixel_rst),
    .en_i   (1'b1),
    .cnt_o  (hcnt),
    .wrap_o (h_wrap)
  );

  vga_counter #(.MAX(VTOTAL), .W(VW)) u_vcnt (
    .clk    (pixel_clk),
    .rst    (pixel_rst),
    .en_i   (h_wrap),
    .cnt_o  (vcnt),
    .wrap_o (v_wrap_unused)
  );

  logic             hs_d, vs_d, blank_d, fs_d;
  logic [RGB_W-1:0] rgb_d;
  logic             hs_q, vs_q, blank_q, fs_q;
  logic [RGB_W-1:0] rgb_q;
  logic             act;
  logic [3:0]       x_lsb, y_lsb;

  // Only the low nibble of x/y matters for the grid, so subtract on 4 bits.
  always_comb begin
    act     = (hcnt >= H_ACT_S) && (vcnt >= V_ACT_S);
    x_lsb   = hcnt[3:0] - H_ACT_S[3:0];
    y_lsb   = vcnt[3:0] - V_ACT_S[3:0];
    hs_d    = ~((hcnt >= H_SYNC_S) && (hcnt < H_SYNC_E));
    vs_d    = ~((vcnt >= V_SYNC_S) && (vcnt < V_SYNC_E));
    blank_d = act;
    rgb_d   = (act && ((x_lsb == 4'd0) || (y_lsb == 4'd0))) ? WHITE : BLACK;
    fs_d    = act && (hcnt == H_ACT_S) && (vcnt == V_ACT_S);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= BLACK;
      fs_q    <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
    end
  end

  assign video.video_CLK   = pixel_clk;
  assign video.video_HS    = hs_q;
  assign video.video_VS    = vs_q;
  assign video.video_BLANK = blank_q;
  assign video.video_RGB   = rgb_q;
  assign video.frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_timing_gen: scoreboard bench with random mid-frame resets,    |
// | comparing every output cycle against an arithmetic screen model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_timing_gen;

  localparam int HD = 160, VD = 90;
  localparam int HFP = 40, HP = 48, HBP = 40;
  localparam int VFP = 13, VP = 3, VBP = 29;
  localparam int HT = HFP + HP + HBP + HD;
  localparam int VT = VFP + VP + VBP + VD;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
    logic        fs;
  } vid_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(HFP), .HPULSE(HP), .HBP(HBP),
    .VFP(VFP), .VPULSE(VP), .VBP(VBP)
  ) dut (
    .pixel_clk (clk),
    .pixel_rst (rst),
    .video     (vif)
  );

  vid_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_fs  = 0;
  int   got_fs  = 0;
  int   pos     = 0;

  // Screen model: position p pixels since reset release -> expected pixel.
  function automatic vid_t model(input int p);
    vid_t e;
    int h, v, x, y;
    bit act;
    h = p % HT;
    v = (p / HT) % VT;
    x = h - (HFP + HP + HBP);
    y = v - (VFP + VP + VBP);
    act = (x >= 0) && (y >= 0);
    e.hs    = !(h >= HFP && h < HFP + HP);
    e.vs    = !(v >= VFP && v < VFP + VP);
    e.blank = act;
    e.rgb   = (act && ((x % 16) == 0 || (y % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
    e.fs    = act && x == 0 && y == 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic vid_t sample();
    vid_t s;
    s.hs    = vif.video_HS;
    s.vs    = vif.video_VS;
    s.blank = vif.video_BLANK;
    s.rgb   = vif.video_RGB;
    s.fs    = vif.frame_start;
    return s;
  endfunction

  initial begin : monitor
    vid_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = sample();
        check("pixel", 64'(g), 64'(e));
        check("video_CLK", 64'(vif.video_CLK), 64'(clk));
        if (g.fs) got_fs++;
      end
    end
  end

  task automatic run(input int n);
    vid_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e = model(pos);
      sb_q.push_back(e);
      if (e.fs) exp_fs++;
      pos++;
    end
  endtask

  task automatic check_reset_vals(input string name);
    vid_t r;
    r.hs = 1'b1; r.vs = 1'b1; r.blank = 1'b0; r.rgb = 24'h0; r.fs = 1'b0;
    check(name, 64'(sample()), 64'(r));
  endtask

  // Assert reset between edges so the async path is what clears the outputs.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("reset_immediate");
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_held");
    rst = 1'b0;
    pos = 0;
  endtask

  initial begin : stimulus
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_initial");
    rst = 1'b0;
    pos = 0;
    run($urandom_range(300, 3000));
    do_reset($urandom_range(1, 13));
    run($urandom_range(500, 5000));
    do_reset($urandom_range(1, 13));
    run(2 * HT * VT + 400);
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("frame_start_count", 64'(got_fs), 64'(exp_fs));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
